// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..MAX_DATA_BITS data bits, none/odd/even/mark parity,
// one or two stop bits, 3-sample majority voting, break detection and a valid/ready output.
module uart_rx_cfg #(
  parameter int MAX_DATA_BITS = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     a_resetn,
  input  logic                     b_tick,
  input  logic                     rx,
  input  logic [3:0]               data_bits,
  input  logic [1:0]               parity,
  input  logic                     stop_bits,
  output logic [MAX_DATA_BITS-1:0] dout,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun_err,
  output logic                     break_det
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] C_MID_LO = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] C_MID    = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] C_MID_HI = TCW'(OVERSAMPLE / 2 + 1);
  localparam logic [TCW-1:0] C_LAST   = TCW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic [TCW-1:0]           r_tc;
  logic                     r_s0;
  logic                     r_s1;
  logic [3:0]               r_bitCnt;
  logic [3:0]               r_nBits;
  logic [1:0]               r_par;
  logic                     r_stop2;
  logic                     r_stopIdx;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic                     r_allZero;
  logic                     r_perr;
  logic                     r_ferr;
  logic                     r_brk;
  logic [MAX_DATA_BITS-1:0] r_dout;
  logic                     r_valid;
  logic                     r_parityErr;
  logic                     r_frameErr;
  logic                     r_overrun;
  logic                     r_break;

  logic                     w_rxs;
  logic                     w_maj;
  logic                     w_decide;
  logic                     w_bitEnd;
  logic                     w_lastStop;
  logic                     w_commit;
  logic                     w_brkNow;
  logic                     w_ferrNext;
  logic                     w_parExp;
  logic                     w_pop;
  logic                     w_startFrame;
  logic [3:0]               w_nBitsCfg;

  assign w_rxs        = r_sync[SYNC_STAGES-1];
  assign w_maj        = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_decide     = b_tick && (r_tc == C_MID_HI);
  assign w_bitEnd     = b_tick && (r_tc == C_LAST);
  assign w_lastStop   = (r_stopIdx == r_stop2);
  assign w_commit     = (r_state == S_STOP) && w_decide && w_lastStop;
  assign w_ferrNext   = r_ferr | ~w_maj;
  assign w_pop        = r_valid && rx_ready;
  assign w_startFrame = (r_state == S_IDLE) && (w_stateNext == S_START);
  // Break is judged on the first stop bit even when the frame carries two.
  assign w_brkNow     = r_stopIdx ? r_brk : (r_allZero & ~w_maj);

  always_comb begin
    w_nBitsCfg = data_bits;
    if (data_bits < 4'd5)
      w_nBitsCfg = 4'd5;
    else if (data_bits > 4'(MAX_DATA_BITS))
      w_nBitsCfg = 4'(MAX_DATA_BITS);
  end

  always_comb begin
    w_parExp = 1'b1;
    case (r_par)
      2'b01:   w_parExp = ~^r_shift;
      2'b10:   w_parExp = ^r_shift;
      default: w_parExp = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn)
      r_state <= S_IDLE;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs)
          w_stateNext = S_START;
      end
      S_START: begin
        if (w_decide && w_maj)
          w_stateNext = S_IDLE;
        else if (w_bitEnd)
          w_stateNext = S_DATA;
      end
      S_DATA: begin
        if (w_bitEnd && (r_bitCnt == r_nBits - 4'd1))
          w_stateNext = (r_par != 2'b00) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_bitEnd)
          w_stateNext = S_STOP;
      end
      S_STOP: begin
        if (w_commit)
          w_stateNext = w_brkNow ? S_BREAK_WAIT : S_IDLE;
      end
      S_BREAK_WAIT: begin
        if (w_rxs)
          w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) begin
      r_sync      <= '1;
      r_tc        <= '0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_bitCnt    <= '0;
      r_nBits     <= 4'd5;
      r_par       <= 2'b00;
      r_stop2     <= 1'b0;
      r_stopIdx   <= 1'b0;
      r_shift     <= '0;
      r_allZero   <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_brk       <= 1'b0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
      r_overrun <= 1'b0;
      r_break   <= 1'b0;

      if (b_tick && (r_tc == C_MID_LO))
        r_s0 <= w_rxs;
      if (b_tick && (r_tc == C_MID))
        r_s1 <= w_rxs;

      if ((r_state == S_IDLE) || (r_state == S_BREAK_WAIT) || (w_stateNext != r_state))
        r_tc <= '0;
      else if (b_tick)
        r_tc <= w_bitEnd ? '0 : r_tc + 1'b1;

      if (w_startFrame) begin
        r_nBits   <= w_nBitsCfg;
        r_par     <= parity;
        r_stop2   <= stop_bits;
        r_bitCnt  <= '0;
        r_stopIdx <= 1'b0;
        r_shift   <= '0;
        r_allZero <= 1'b1;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
        r_brk     <= 1'b0;
      end

      case (r_state)
        S_DATA: begin
          if (w_decide) begin
            for (int i = 0; i < MAX_DATA_BITS; i++)
              if (r_bitCnt == 4'(i))
                r_shift[i] <= w_maj;
            r_allZero <= r_allZero & ~w_maj;
          end
          if (w_bitEnd)
            r_bitCnt <= r_bitCnt + 4'd1;
        end
        S_PARITY: begin
          if (w_decide) begin
            r_perr    <= (w_maj != w_parExp);
            r_allZero <= r_allZero & ~w_maj;
          end
        end
        S_STOP: begin
          if (w_decide) begin
            r_ferr <= w_ferrNext;
            if (!r_stopIdx)
              r_brk <= w_brkNow;
          end
          if (w_bitEnd)
            r_stopIdx <= 1'b1;
        end
        default: ;
      endcase

      // A pop and a commit in the same clk hand the slot straight to the new frame.
      if (w_pop)
        r_valid <= 1'b0;
      if (w_commit) begin
        if (w_brkNow) begin
          r_break <= 1'b1;
        end else if (!r_valid || w_pop) begin
          r_dout      <= r_shift;
          r_parityErr <= r_perr;
          r_frameErr  <= w_ferrNext;
          r_valid     <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign dout        = r_dout;
  assign rx_valid    = r_valid;
  assign parity_err  = r_parityErr;
  assign frame_err   = r_frameErr;
  assign overrun_err = r_overrun;
  assign break_det   = r_break;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven tick-aligned so the commit clk of each
// frame is known exactly; expected values are hand-computed constants.
module tb_uart_rx_cfg;

  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            a_resetn = 1'b1;
  logic            b_tick = 1'b0;
  logic            rx = 1'b1;
  logic [3:0]      data_bits = 4'd8;
  logic [1:0]      parity = 2'b00;
  logic            stop_bits = 1'b0;
  logic            rx_ready = 1'b0;
  logic [MAXB-1:0] dout;
  logic            rx_valid;
  logic            parity_err;
  logic            frame_err;
  logic            overrun_err;
  logic            break_det;

  int total = 0;
  int bad = 0;
  int tdiv = 0;
  int ovrCount = 0;
  int brkCount = 0;
  logic [15:0] fr;
  int frN;

  uart_rx_cfg #(.MAX_DATA_BITS(MAXB), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .a_resetn(a_resetn), .b_tick(b_tick), .rx(rx),
    .data_bits(data_bits), .parity(parity), .stop_bits(stop_bits),
    .dout(dout), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .break_det(break_det)
  );

  always #5 clk = ~clk;

  // One b_tick every four clks.
  always @(negedge clk) begin
    tdiv = (tdiv == 3) ? 0 : tdiv + 1;
    b_tick = (tdiv == 0);
  end

  always @(negedge clk) begin
    if (overrun_err === 1'b1) ovrCount++;
    if (break_det === 1'b1) brkCount++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (b_tick !== 1'b1);
    @(negedge clk);
  endtask

  function automatic void buildFrame(input logic [8:0] data, input int nData, input logic hasPar,
                                     input logic parBit, input logic twoStop, input logic stop2Val,
                                     output logic [15:0] bits, output int n);
    bits = '0;
    n = 1;
    for (int i = 0; i < nData; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (hasPar) begin
      bits[n] = parBit;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (twoStop) begin
      bits[n] = stop2Val;
      n++;
    end
  endfunction

  // Drives each bit for 16 ticks; returns 9 ticks into the final bit, one tick before commit.
  task automatic applyStimulus(input logic [15:0] bits, input int n, input int glitch);
    tick();
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      if (i == n - 1) begin
        repeat (9) tick();
      end else if (i == glitch) begin
        repeat (8) tick();
        rx = ~bits[i];
        tick();
        rx = bits[i];
        repeat (7) tick();
      end else begin
        repeat (16) tick();
      end
    end
  endtask

  task automatic toCommit(input logic ready);
    repeat (3) @(negedge clk);
    rx_ready = ready;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic popFrame(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput(tag, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    #1 a_resetn = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_dout", {24'd0, dout}, 32'd0);
    checkOutput("rst_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst_perr", {31'd0, parity_err}, 32'd0);
    checkOutput("rst_ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_ovr", {31'd0, overrun_err}, 32'd0);
    checkOutput("rst_brk", {31'd0, break_det}, 32'd0);
    a_resetn = 1'b1;
    repeat (8) tick();

    // 8N1 0xA5
    buildFrame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("a5_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("a5_dout", {24'd0, dout}, 32'h0A5);
    checkOutput("a5_perr", {31'd0, parity_err}, 32'd0);
    checkOutput("a5_ferr", {31'd0, frame_err}, 32'd0);
    popFrame("a5_pop");
    repeat (8) tick();

    // 8E1 0x03, wrong then right parity bit
    parity = 2'b10;
    buildFrame(9'h003, 8, 1'b1, 1'b1, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("e_bad_dout", {24'd0, dout}, 32'h003);
    checkOutput("e_bad_perr", {31'd0, parity_err}, 32'd1);
    popFrame("e_bad_pop");
    repeat (8) tick();
    buildFrame(9'h003, 8, 1'b1, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("e_ok_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("e_ok_perr", {31'd0, parity_err}, 32'd0);
    popFrame("e_ok_pop");
    repeat (8) tick();

    // Mark parity with a 0 parity bit
    parity = 2'b11;
    buildFrame(9'h003, 8, 1'b1, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("mark_perr", {31'd0, parity_err}, 32'd1);
    popFrame("mark_pop");
    parity = 2'b00;
    repeat (8) tick();

    // False start and mid-bit glitch
    tick();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    checkOutput("false_start", {31'd0, rx_valid}, 32'd0);
    buildFrame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, 2);
    toCommit(1'b0);
    checkOutput("glitch_dout", {24'd0, dout}, 32'h055);
    popFrame("glitch_pop");
    repeat (8) tick();

    // 5 data bits, two stop bits, second stop low
    data_bits = 4'd5;
    stop_bits = 1'b1;
    buildFrame(9'h01F, 5, 1'b0, 1'b0, 1'b1, 1'b0, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    rx = 1'b1;
    checkOutput("s2_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("s2_dout", {24'd0, dout}, 32'h01F);
    checkOutput("s2_ferr", {31'd0, frame_err}, 32'd1);
    repeat (30) tick();
    popFrame("s2_pop");

    // data_bits below 5 is treated as 5
    data_bits = 4'd2;
    stop_bits = 1'b0;
    buildFrame(9'h015, 5, 1'b0, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("clamp_dout", {24'd0, dout}, 32'h015);
    checkOutput("clamp_ferr", {31'd0, frame_err}, 32'd0);
    popFrame("clamp_pop");
    data_bits = 4'd8;
    repeat (8) tick();

    // Break: line low for two frame times
    tick();
    rx = 1'b0;
    repeat (320) tick();
    checkOutput("brk_count", brkCount, 32'd1);
    checkOutput("brk_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("brk_ovr", ovrCount, 32'd0);
    rx = 1'b1;
    repeat (20) tick();
    buildFrame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("post_brk_dout", {24'd0, dout}, 32'h03C);
    checkOutput("post_brk_valid", {31'd0, rx_valid}, 32'd1);
    popFrame("post_brk_pop");
    repeat (8) tick();

    // Overrun, then pop coinciding with commit
    buildFrame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("ovr1_dout", {24'd0, dout}, 32'h011);
    repeat (8) tick();
    buildFrame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, fr, frN);
    applyStimulus(fr, frN, -1);
    toCommit(1'b0);
    checkOutput("ovr2_pulse", {31'd0, overrun_err}, 32'd1);
    checkOutput("ovr2_dout", {24'd0, dout}, 32'h011);
    repeat (8) tick();
    applyStimulus(fr, frN, -1);
    toCommit(1'b1);
    checkOutput("coinc_dout", {24'd0, dout}, 32'h022);
    checkOutput("coinc_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("coinc_ovr", {31'd0, overrun_err}, 32'd0);
    repeat (4) tick();
    checkOutput("ovr_total", ovrCount, 32'd1);
    checkOutput("coinc_hold", {31'd0, rx_valid}, 32'd1);

    // Reset in the middle of a frame
    tick();
    rx = 1'b0;
    repeat (16) tick();
    rx = 1'b1;
    repeat (8) tick();
    a_resetn = 1'b0;
    #1;
    checkOutput("mid_rst_dout", {24'd0, dout}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    a_resetn = 1'b1;
    repeat (200) tick();
    checkOutput("mid_rst_nodata", {31'd0, rx_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
